// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction port A and data port B share one physical memory port.
// Define ARB_ROUND_ROBIN_EN for alternating priority on contention; otherwise B always beats A.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    localparam int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read_a,
    input  logic [ADDR_WIDTH-1:0] mem_address_a,
    output logic                  mem_resp_a,
    output logic [DATA_WIDTH-1:0] mem_rdata_a,
    input  logic                  mem_read_b,
    input  logic                  mem_write_b,
    input  logic [ADDR_WIDTH-1:0] mem_address_b,
    input  logic [DATA_WIDTH-1:0] mem_wdata_b,
    input  logic [MASK_WIDTH-1:0] mem_wmask_b,
    output logic                  mem_resp_b,
    output logic [DATA_WIDTH-1:0] mem_rdata_b,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [DATA_WIDTH-1:0] pmem_wdata,
    output logic [MASK_WIDTH-1:0] pmem_wmask,
    input  logic                  pmem_resp,
    input  logic [DATA_WIDTH-1:0] pmem_rdata,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_op_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [MASK_WIDTH-1:0] r_wmask;

    logic w_req_a;
    logic w_req_b;
    logic w_pick_b;
    logic w_serving;

    assign w_req_a = mem_read_a;
    assign w_req_b = mem_read_b | mem_write_b;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = B was granted last; on contention the other port wins.
    logic r_last_grant_b;

    assign w_pick_b = w_req_b & (~w_req_a | ~r_last_grant_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant_b <= 1'b0;
        end else if (r_state == IDLE && (w_req_a || w_req_b)) begin
            r_last_grant_b <= w_pick_b;
        end
    end
`else
    assign w_pick_b = w_req_b;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_pick_b) begin
                    w_next_state = SERVE_B;
                end else if (w_req_a) begin
                    w_next_state = SERVE_A;
                end
            end
            SERVE_A, SERVE_B: begin
                if (pmem_resp) begin
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Request fields are latched only at the granting edge and stay frozen until the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wmask    <= '0;
        end else if (r_state == IDLE) begin
            if (w_pick_b) begin
                r_op_write <= mem_write_b;
                r_addr     <= mem_address_b;
                r_wdata    <= mem_wdata_b;
                r_wmask    <= mem_write_b ? mem_wmask_b : '1;
            end else if (w_req_a) begin
                r_op_write <= 1'b0;
                r_addr     <= mem_address_a;
                r_wdata    <= '0;
                r_wmask    <= '1;
            end
        end
    end

    assign w_serving    = (r_state == SERVE_A) || (r_state == SERVE_B);
    assign pmem_address = r_addr;
    assign pmem_wdata   = r_wdata;
    assign pmem_wmask   = r_wmask;
    assign o_dbg_state  = r_state;

    // A withdrawn request still finishes on pmem, but its owner gets no response pulse.
    always_comb begin
        pmem_read   = w_serving & ~r_op_write;
        pmem_write  = w_serving & r_op_write;
        mem_resp_a  = (r_state == SERVE_A) & pmem_resp & w_req_a;
        mem_resp_b  = (r_state == SERVE_B) & pmem_resp & w_req_b;
        mem_rdata_a = mem_resp_a ? pmem_rdata : '0;
        mem_rdata_b = mem_resp_b ? pmem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: memory responder model, grant/response monitor, directed and random runs.
// Expected grant order follows ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MW = 2;
  localparam int GW = 1 + MW + DW + AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_read_a = 1'b0;
  logic [AW-1:0] mem_address_a = '0;
  logic          mem_resp_a;
  logic [DW-1:0] mem_rdata_a;
  logic          mem_read_b = 1'b0;
  logic          mem_write_b = 1'b0;
  logic [AW-1:0] mem_address_b = '0;
  logic [DW-1:0] mem_wdata_b = '0;
  logic [MW-1:0] mem_wmask_b = '0;
  logic          mem_resp_b;
  logic [DW-1:0] mem_rdata_b;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [DW-1:0] pmem_wdata;
  logic [MW-1:0] pmem_wmask;
  logic          pmem_resp = 1'b0;
  logic [DW-1:0] pmem_rdata = '0;
  logic [1:0]    o_dbg_state;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_a(mem_read_a), .mem_address_a(mem_address_a),
    .mem_resp_a(mem_resp_a), .mem_rdata_a(mem_rdata_a),
    .mem_read_b(mem_read_b), .mem_write_b(mem_write_b),
    .mem_address_b(mem_address_b), .mem_wdata_b(mem_wdata_b), .mem_wmask_b(mem_wmask_b),
    .mem_resp_b(mem_resp_b), .mem_rdata_b(mem_rdata_b),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_wmask(pmem_wmask),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [GW-1:0] grant_q[$];
  logic [DW-1:0] exp_a_q[$];
  logic [DW-1:0] exp_b_q[$];
  int rsp_lat = 3;
  bit spurious = 1'b0;
  bit tb_last_b = 1'b0;

  function automatic logic [DW-1:0] model_rdata(input logic [AW-1:0] a);
    return (a == 16'h0040) ? 16'h1234 : (a ^ 16'hC3A5);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // physical memory model: responds rsp_lat cycles after the strobe is first seen
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      if (pmem_read || pmem_write) begin
        if (cnt == rsp_lat) begin
          pmem_resp  = 1'b1;
          pmem_rdata = model_rdata(pmem_address);
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
        if (spurious) begin
          pmem_resp  = 1'b1;
          pmem_rdata = 16'hDEAD;
          spurious   = 1'b0;
        end
      end
    end
  end

  // monitor: grant order / captured fields, response data, exclusivity
  initial begin
    bit prev_strobe;
    prev_strobe = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (pmem_read || pmem_write) check("strobe_excl", 64'(pmem_read & pmem_write), 64'd0);
        if ((pmem_read || pmem_write) && !prev_strobe) begin
          if (grant_q.size() == 0) check("grant_unexp", 64'd1, 64'd0);
          else check("grant", 64'({pmem_write, pmem_wmask, pmem_wdata, pmem_address}),
                     64'(grant_q.pop_front()));
        end
        if (mem_resp_a) begin
          check("resp_excl", 64'(mem_resp_b), 64'd0);
          if (exp_a_q.size() == 0) check("resp_a_unexp", 64'd1, 64'd0);
          else check("rdata_a", 64'(mem_rdata_a), 64'(exp_a_q.pop_front()));
        end else if (pmem_resp) begin
          check("rdata_a_zero", 64'(mem_rdata_a), 64'd0);
        end
        if (mem_resp_b) begin
          if (exp_b_q.size() == 0) check("resp_b_unexp", 64'd1, 64'd0);
          else check("rdata_b", 64'(mem_rdata_b), 64'(exp_b_q.pop_front()));
        end else if (pmem_resp) begin
          check("rdata_b_zero", 64'(mem_rdata_b), 64'd0);
        end
      end
      prev_strobe = pmem_read | pmem_write;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [AW-1:0] addr);
    grant_q.push_back({1'b0, 2'b11, 16'h0000, addr});
    exp_a_q.push_back(model_rdata(addr));
  endtask

  task automatic push_b(input logic [AW-1:0] addr, input bit wr, input logic [MW-1:0] mask,
                        input logic [DW-1:0] wdata);
    grant_q.push_back({wr, wr ? mask : 2'b11, wdata, addr});
    exp_b_q.push_back(model_rdata(addr));
  endtask

  task automatic wait_resp(input bit port_b, input bit scramble);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (scramble && i > 0) begin
        if (port_b) begin
          mem_address_b = 16'($urandom);
          mem_wdata_b   = 16'($urandom);
        end else begin
          mem_address_a = 16'($urandom);
        end
      end
      @(negedge clk);
      got = port_b ? mem_resp_b : mem_resp_a;
    end
    check(port_b ? "timeout_b" : "timeout_a", 64'(got), 64'd1);
  endtask

  task automatic run_a(input logic [AW-1:0] addr, input bit scramble);
    mem_read_a = 1'b1;
    mem_address_a = addr;
    push_a(addr);
    tb_last_b = 1'b0;
    wait_resp(1'b0, scramble);
    tick();
    mem_read_a = 1'b0;
    tick();
  endtask

  task automatic run_b(input logic [AW-1:0] addr, input bit wr, input bit rd,
                       input logic [MW-1:0] mask, input logic [DW-1:0] wdata, input bit scramble);
    mem_read_b = rd;
    mem_write_b = wr;
    mem_address_b = addr;
    mem_wdata_b = wdata;
    mem_wmask_b = mask;
    push_b(addr, wr, mask, wdata);
    tb_last_b = 1'b1;
    wait_resp(1'b1, scramble);
    tick();
    mem_read_b = 1'b0;
    mem_write_b = 1'b0;
    tick();
  endtask

  task automatic run_both(input logic [AW-1:0] addr_a, input logic [AW-1:0] addr_b);
    bit first_b;
`ifdef ARB_ROUND_ROBIN_EN
    first_b = !tb_last_b;
`else
    first_b = 1'b1;
`endif
    mem_read_a = 1'b1;
    mem_address_a = addr_a;
    mem_read_b = 1'b1;
    mem_address_b = addr_b;
    mem_wdata_b = 16'h0000;
    if (first_b) begin
      push_b(addr_b, 1'b0, 2'b11, 16'h0000);
      push_a(addr_a);
      wait_resp(1'b1, 1'b0);
      tick();
      mem_read_b = 1'b0;
      wait_resp(1'b0, 1'b0);
      tick();
      mem_read_a = 1'b0;
      tb_last_b = 1'b0;
    end else begin
      push_a(addr_a);
      push_b(addr_b, 1'b0, 2'b11, 16'h0000);
      wait_resp(1'b0, 1'b0);
      tick();
      mem_read_a = 1'b0;
      wait_resp(1'b1, 1'b0);
      tick();
      mem_read_b = 1'b0;
      tb_last_b = 1'b1;
    end
    tick();
  endtask

  initial begin
    bit got;
    bit wr;

    // reset held with a pending A read
    mem_read_a = 1'b1;
    mem_address_a = 16'h0040;
    push_a(16'h0040);
    repeat (3) @(posedge clk);
    #1;
    check("rst_pmem_read", 64'(pmem_read), 64'd0);
    check("rst_pmem_write", 64'(pmem_write), 64'd0);
    check("rst_resp_a", 64'(mem_resp_a), 64'd0);
    check("rst_resp_b", 64'(mem_resp_b), 64'd0);
    check("rst_state", 64'(o_dbg_state), 64'd0);
    check("rst_fields", 64'({pmem_address, pmem_wdata, pmem_wmask}), 64'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("rel_pmem_read", 64'(pmem_read), 64'd1);
    wait_resp(1'b0, 1'b0);
    tick();
    check("done_state", 64'(o_dbg_state), 64'd3);
    check("done_strobe", 64'(pmem_read | pmem_write), 64'd0);
    mem_read_a = 1'b0;
    tick();

    // B store byte, then varied latencies with request fields changing mid-transaction
    run_b(16'h0101, 1'b1, 1'b0, 2'b10, 16'hABAB, 1'b0);
    rsp_lat = 1;
    run_a(16'h0044, 1'b1);
    rsp_lat = 0;
    run_b(16'h2222, 1'b0, 1'b1, 2'b00, 16'h1111, 1'b1);
    run_b(16'h0300, 1'b1, 1'b1, 2'b01, 16'h5555, 1'b0);

    // contention: after an A grant, then after a B grant
    rsp_lat = 2;
    run_a(16'h0010, 1'b0);
    run_both(16'h0042, 16'h2000);
    run_b(16'h0500, 1'b0, 1'b1, 2'b00, 16'h0000, 1'b0);
    run_both(16'h0046, 16'h2002);

    // pmem_resp while idle must not produce a response
    spurious = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (pmem_resp) begin
        check("spur_resp_a", 64'(mem_resp_a), 64'd0);
        check("spur_resp_b", 64'(mem_resp_b), 64'd0);
        got = 1'b1;
      end
    end
    check("spur_seen", 64'(got), 64'd1);
    tick();

    // A withdraws mid-service
    rsp_lat = 4;
    mem_read_a = 1'b1;
    mem_address_a = 16'h0600;
    grant_q.push_back({1'b0, 2'b11, 16'h0000, 16'h0600});
    tb_last_b = 1'b0;
    tick();
    tick();
    mem_read_a = 1'b0;
    @(negedge clk);
    check("wd_hold", 64'(pmem_read), 64'd1);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pmem_resp) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("wd_pmem_resp", 64'(got), 64'd1);
    check("wd_no_resp_a", 64'(mem_resp_a), 64'd0);
    tick();
    check("wd_done", 64'(o_dbg_state), 64'd3);
    check("wd_strobe_off", 64'(pmem_read), 64'd0);
    tick();

    // reset pulse mid-service of B
    rsp_lat = 6;
    mem_read_b = 1'b1;
    mem_address_b = 16'h3000;
    mem_wdata_b = 16'h0000;
    grant_q.push_back({1'b0, 2'b11, 16'h0000, 16'h3000});
    tick();
    tick();
    @(negedge clk);
    check("ab_active", 64'(pmem_read), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ab_strobes", 64'(pmem_read | pmem_write), 64'd0);
    check("ab_resp_b", 64'(mem_resp_b), 64'd0);
    check("ab_state", 64'(o_dbg_state), 64'd0);
    mem_read_b = 1'b0;
    tick();
    rst_n = 1'b1;
    tb_last_b = 1'b0;
    tick();
    tick();
    check("ab_idle", 64'(o_dbg_state), 64'd0);

    // random single-port traffic
    for (int k = 0; k < 8; k++) begin
      rsp_lat = $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 1) begin
        run_a(16'($urandom), 1'b1);
      end else begin
        wr = 1'($urandom_range(0, 1));
        run_b(16'($urandom), wr, !wr, 2'($urandom_range(1, 3)), 16'($urandom), 1'b1);
      end
    end

    repeat (3) tick();
    check("left_grant", 64'(grant_q.size()), 64'd0);
    check("left_a", 64'(exp_a_q.size()), 64'd0);
    check("left_b", 64'(exp_b_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
